// File: rtl/alu_hex_scan_display_pkg.sv
// Shared definitions for the registered ALU and its scanned hex display.
// - MODE_* : ALU operation encodings carried on the 2-bit mode input
// - SEG_BLANK : segment pattern for an unlit digit, active-low {g,f,e,d,c,b,a}
// - hex_to_seg() : nibble to active-low 7-segment pattern
package alu_disp_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_AND = 2'b10;
  localparam logic [1:0] MODE_OR  = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_hex_scan_display_hex7seg.sv
// Combinational hex digit decoder.
// - nibble in  4 : hex value to show
// - seg    out 7 : segments {g,f,e,d,c,b,a}, active-low
module hex7seg
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/alu_hex_scan_display.sv
// Registered ALU with a time-multiplexed, leading-zero-blanked hex display.
// - clk       in  1       system clock
// - clr       in  1       synchronous reset, active-high (wins over load)
// - left      in  WIDTH   operand A
// - right     in  WIDTH   operand B
// - mode      in  2       00 add, 01 sub, 10 AND, 11 OR
// - load      in  1       capture operands/mode this edge
// - res_valid out 1       one-cycle pulse when result/flag update
// - result    out WIDTH   held ALU result
// - flag      out 1       carry (add) / borrow (sub) / 0 (logic ops)
// - g_to_a    out 7       active-low segments of the active digit
// - an        out NDIGITS active-low digit anodes
// - dp        out 1       active-low decimal point, lit on digit 0 when flag=1
module alu_hex_scan_display
  import alu_disp_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NDIGITS      = 4,
  parameter int REFRESH_BITS = 17,
  parameter int BLANK_LZ     = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [WIDTH-1:0]   left,
  input  logic [WIDTH-1:0]   right,
  input  logic [1:0]         mode,
  input  logic               load,
  output logic               res_valid,
  output logic [WIDTH-1:0]   result,
  output logic               flag,
  output logic [6:0]         g_to_a,
  output logic [NDIGITS-1:0] an,
  output logic               dp
);

  localparam int SEL_W = $clog2(NDIGITS);
  localparam int PAD_W = NDIGITS * 4;

  // Stage 1: captured operands
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic [1:0]       mode_q, mode_d;
  logic             ld1_q, ld1_d;

  // Stage 2: held result
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
  logic             res_valid_q, res_valid_d;

  // Scan state and registered display outputs
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [NDIGITS-1:0]      an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  // ALU evaluated one bit wider so bit WIDTH is the carry/borrow.
  logic [WIDTH:0] alu_ext;

  always_comb begin
    alu_ext = '0;
    case (mode_q)
      MODE_ADD: alu_ext = {1'b0, left_q} + {1'b0, right_q};
      MODE_SUB: alu_ext = {1'b0, left_q} - {1'b0, right_q};
      MODE_AND: alu_ext = {1'b0, left_q & right_q};
      default:  alu_ext = {1'b0, left_q | right_q};
    endcase
  end

  always_comb begin
    left_d      = load ? left  : left_q;
    right_d     = load ? right : right_q;
    mode_d      = load ? mode  : mode_q;
    ld1_d       = load;
    result_d    = ld1_q ? alu_ext[WIDTH-1:0] : result_q;
    flag_d      = ld1_q ? alu_ext[WIDTH]     : flag_q;
    res_valid_d = ld1_q;
    cnt_d       = cnt_q + 1'b1;
  end

  // Result zero-extended to whole nibbles so digits beyond WIDTH read as 0.
  logic [PAD_W-1:0]   result_pad;
  logic [3:0]         nib [NDIGITS];
  logic [NDIGITS-1:0] upper_zero;

  assign result_pad = PAD_W'(result_q);

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign nib[gi] = result_pad[4*gi +: 4];
      // Digit gi and every more-significant digit are zero.
      assign upper_zero[gi] = (result_pad[PAD_W-1:4*gi] == '0);
    end
  endgenerate

  logic [SEL_W-1:0] sel;
  logic [3:0]       sel_nib;
  logic [6:0]       sel_seg;
  logic             blank;

  assign sel = cnt_q[REFRESH_BITS-1 -: SEL_W];

  hex7seg u_hex7seg (
    .nibble (sel_nib),
    .seg    (sel_seg)
  );

  always_comb begin
    sel_nib = nib[sel];
    // Digit 0 is never blanked so a zero result still shows '0'.
    blank   = (BLANK_LZ != 0) && (sel != '0) && upper_zero[sel];
    an_d    = blank ? '1 : ~(NDIGITS'(1) << sel);
    seg_d   = blank ? SEG_BLANK : sel_seg;
    dp_d    = !((sel == '0) && flag_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      left_q      <= '0;
      right_q     <= '0;
      mode_q      <= MODE_ADD;
      ld1_q       <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      left_q      <= left_d;
      right_q     <= right_d;
      mode_q      <= mode_d;
      ld1_q       <= ld1_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign flag      = flag_q;
  assign an        = an_q;
  assign g_to_a    = seg_q;
  assign dp        = dp_q;

endmodule
